// File: rtl/mos_microseq_if.sv
// mos_microseq_if -- sequencer <-> PLA bus.
//   opcode    : instruction register, sequencer -> PLA
//   tstate    : current T-state, sequencer -> PLA
//   ctrl_in   : PLA control word for (opcode, tstate), PLA -> sequencer
//   step_last : current T-state is the instruction's final one, PLA -> sequencer
// Modports: master = sequencer side, slave = PLA side.
interface mos_microseq_if #(
    parameter int unsigned CW = 26,
    parameter int unsigned TW = 3
);
    logic [7:0]    opcode;
    logic [TW-1:0] tstate;
    logic [CW-1:0] ctrl_in;
    logic          step_last;

    modport master (
        output opcode,
        output tstate,
        input  ctrl_in,
        input  step_last
    );

    modport slave (
        input  opcode,
        input  tstate,
        output ctrl_in,
        output step_last
    );
endinterface

// File: rtl/mos_microseq.sv
// mos_microseq -- 6502 micro-step sequencer.
// Owns the instruction register, the T-state counter, reset/NMI/IRQ sequencing,
// RDY stalling and the registered PLA control word.
// Ports:
//   clk, rst_n       : core clock, async active-low reset
//   i_insn           : data-bus byte, valid in the opcode fetch cycle
//   i_rdy            : 1 = advance, 0 = stall
//   i_nmi_n          : NMI, falling-edge sensitive
//   i_irq_n          : IRQ, level sensitive, active-low
//   i_i_flag         : P.I, masks IRQ
//   pla              : PLA bus (opcode/tstate out, ctrl_in/step_last in)
//   o_ctrl_out       : registered control word to the datapath
//   o_sync           : opcode-fetch cycle of a normal instruction
//   o_int_src        : active sequence 0 none, 1 IRQ, 2 NMI, 3 RST
//   o_vec_lo         : low byte of the vector address
//   o_t_fault        : sticky, an instruction ran MAX_T steps without step_last
// Optional feature, macro SO_EN: adds i_so_n and o_set_v (one-cycle pulse after
// a falling edge of i_so_n).
module mos_microseq #(
    parameter int unsigned CW     = 26,
    parameter int unsigned MAX_T  = 8,
    parameter logic [7:0]  BRK_OP = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    i_insn,
    input  logic          i_rdy,
    input  logic          i_nmi_n,
    input  logic          i_irq_n,
    input  logic          i_i_flag,
`ifdef SO_EN
    input  logic          i_so_n,
    output logic          o_set_v,
`endif
    mos_microseq_if.master pla,
    output logic [CW-1:0] o_ctrl_out,
    output logic          o_sync,
    output logic [1:0]    o_int_src,
    output logic [7:0]    o_vec_lo,
    output logic          o_t_fault
);
    localparam int unsigned   TW    = $clog2(MAX_T);
    localparam logic [TW-1:0] TLast = TW'(MAX_T - 1);

    typedef enum logic [1:0] {
        SrcNone = 2'd0,
        SrcIrq  = 2'd1,
        SrcNmi  = 2'd2,
        SrcRst  = 2'd3
    } src_e;

    logic [7:0]    r_opcode,   w_opcode;
    logic [TW-1:0] r_tstate,   w_tstate;
    logic [CW-1:0] r_ctrl_out, w_ctrl_out;
    src_e          r_int_src,  w_int_src;
    logic [7:0]    r_vec_lo,   w_vec_lo;
    logic          r_nmi_pend, w_nmi_pend;
    logic          r_t_fault,  w_t_fault;
    logic          r_nmi_q;
    logic          w_nmi_fall;
    logic          w_end;

    assign w_nmi_fall = r_nmi_q & ~i_nmi_n;
    // The counter never passes TLast: that step ends the instruction regardless.
    assign w_end      = i_rdy & (pla.step_last | (r_tstate == TLast));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode   <= BRK_OP;
            r_tstate   <= '0;
            r_ctrl_out <= '0;
            r_int_src  <= SrcRst;
            r_vec_lo   <= 8'hFC;
            r_nmi_pend <= 1'b0;
            r_t_fault  <= 1'b0;
            r_nmi_q    <= 1'b1;
        end else begin
            r_opcode   <= w_opcode;
            r_tstate   <= w_tstate;
            r_ctrl_out <= w_ctrl_out;
            r_int_src  <= w_int_src;
            r_vec_lo   <= w_vec_lo;
            r_nmi_pend <= w_nmi_pend;
            r_t_fault  <= w_t_fault;
            r_nmi_q    <= i_nmi_n;  // sampled even while stalled
        end
    end

    always_comb begin
        w_opcode   = r_opcode;
        w_tstate   = r_tstate;
        w_ctrl_out = r_ctrl_out;
        w_int_src  = r_int_src;
        w_vec_lo   = r_vec_lo;
        w_nmi_pend = r_nmi_pend;
        w_t_fault  = r_t_fault;

        if (i_rdy) begin
            w_ctrl_out = pla.ctrl_in;
            w_tstate   = w_end ? '0 : r_tstate + TW'(1);
            if ((r_tstate == TLast) && !pla.step_last) begin
                w_t_fault = 1'b1;
            end
        end

        // Only the already-registered nmi_pend is considered here, so an edge
        // arriving on the end edge itself waits for the following end.
        if (w_end) begin
            if (r_nmi_pend) begin
                w_opcode  = BRK_OP;
                w_int_src = SrcNmi;
                w_vec_lo  = 8'hFA;
            end else if (!i_irq_n && !i_i_flag) begin
                w_opcode  = BRK_OP;
                w_int_src = SrcIrq;
                w_vec_lo  = 8'hFE;
            end else begin
                w_opcode  = i_insn;
                w_int_src = SrcNone;
                w_vec_lo  = 8'hFE;
            end
        end

        // Launch wins over a coincident edge; a second edge while pending is dropped.
        if (w_end && r_nmi_pend) begin
            w_nmi_pend = 1'b0;
        end else if (w_nmi_fall) begin
            w_nmi_pend = 1'b1;
        end
    end

`ifdef SO_EN
    logic r_so_q;
    logic r_set_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_so_q  <= 1'b1;
            r_set_v <= 1'b0;
        end else begin
            r_so_q  <= i_so_n;
            r_set_v <= r_so_q & ~i_so_n;
        end
    end

    assign o_set_v = r_set_v;
`endif

    assign pla.opcode = r_opcode;
    assign pla.tstate = r_tstate;
    assign o_ctrl_out = r_ctrl_out;
    assign o_int_src  = r_int_src;
    assign o_vec_lo   = r_vec_lo;
    assign o_t_fault  = r_t_fault;
    assign o_sync     = (r_tstate == '0) && (r_int_src == SrcNone);
endmodule

// File: tb/tb_mos_microseq.sv
module tb_mos_microseq;
    localparam int unsigned CW = 26;
    localparam int unsigned TW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    insn;
    logic          rdy;
    logic          nmi_n;
    logic          irq_n;
    logic          i_flag;
    logic [CW-1:0] ctrl_out;
    logic          sync;
    logic [1:0]    int_src;
    logic [7:0]    vec_lo;
    logic          t_fault;
`ifdef SO_EN
    logic          so_n;
    logic          set_v;
`endif

    mos_microseq_if #(.CW(CW), .TW(TW)) pla_if ();

    mos_microseq #(.CW(CW), .MAX_T(8), .BRK_OP(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_insn     (insn),
        .i_rdy      (rdy),
        .i_nmi_n    (nmi_n),
        .i_irq_n    (irq_n),
        .i_i_flag   (i_flag),
`ifdef SO_EN
        .i_so_n     (so_n),
        .o_set_v    (set_v),
`endif
        .pla        (pla_if.master),
        .o_ctrl_out (ctrl_out),
        .o_sync     (sync),
        .o_int_src  (int_src),
        .o_vec_lo   (vec_lo),
        .o_t_fault  (t_fault)
    );

    always #5 clk = ~clk;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [CW-1:0] sb_q[$];
    logic [CW-1:0] exp_ctrl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, push the expected ctrl_out, pop and compare after the edge.
    task automatic tick(input logic r, input logic sl, input logic [7:0] op_in);
        rdy                 = r;
        pla_if.step_last    = sl;
        insn                = op_in;
        pla_if.ctrl_in      = CW'($urandom);
        if (r) sb_q.push_back(pla_if.ctrl_in);
        @(posedge clk);
        #1;
        if (r) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL scoreboard: observed empty queue expected an entry");
            end else begin
                exp_ctrl = sb_q.pop_front();
            end
        end
        check("ctrl_out", 32'(ctrl_out), 32'(exp_ctrl));
    endtask

    task automatic st(input string tag, input int t, input logic [7:0] op, input int src,
                      input logic [7:0] vec);
        check($sformatf("%s.tstate", tag), 32'(pla_if.tstate), t);
        check($sformatf("%s.opcode", tag), 32'(pla_if.opcode), 32'(op));
        check($sformatf("%s.int_src", tag), 32'(int_src), src);
        check($sformatf("%s.vec_lo", tag), 32'(vec_lo), 32'(vec));
        check($sformatf("%s.sync", tag), 32'(sync), 32'((t == 0) && (src == 0)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        rdy              = 1'b1;
        insn             = 8'hEA;
        nmi_n            = 1'b1;
        irq_n            = 1'b1;
        i_flag           = 1'b1;
        pla_if.ctrl_in   = '0;
        pla_if.step_last = 1'b0;
`ifdef SO_EN
        so_n             = 1'b1;
`endif
        exp_ctrl         = '0;
        repeat (3) @(posedge clk);
        #1;
        st("reset", 0, 8'h00, 3, 8'hFC);
        check("reset.ctrl_out", 32'(ctrl_out), 0);
        check("reset.t_fault", 32'(t_fault), 0);
        rst_n = 1'b1;

        // Reset sequence T0..T6, vector FC throughout.
        for (int t = 1; t <= 6; t++) begin
            tick(1'b1, 1'b0, 8'hEA);
            st($sformatf("rst_seq%0d", t), t, 8'h00, 3, 8'hFC);
        end
        tick(1'b1, 1'b1, 8'hA9);
        st("rst_end", 0, 8'hA9, 0, 8'hFE);

        // LDA #: 0,1,0.
        tick(1'b1, 1'b0, 8'hEA);
        st("lda_t1", 1, 8'hA9, 0, 8'hFE);
        tick(1'b1, 1'b1, 8'hAD);
        st("lda_end", 0, 8'hAD, 0, 8'hFE);

        // Stall at T2 with an NMI edge inside the stall.
        tick(1'b1, 1'b0, 8'hEA);
        tick(1'b1, 1'b0, 8'hEA);
        st("pre_stall", 2, 8'hAD, 0, 8'hFE);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) nmi_n = 1'b0;
            tick(1'b0, 1'b1, 8'hEA);
            st($sformatf("stall%0d", i), 2, 8'hAD, 0, 8'hFE);
        end
        tick(1'b1, 1'b1, 8'hEA);
        st("nmi_taken", 0, 8'h00, 2, 8'hFA);

        // NMI sequence; IRQ asserted but masked.
        irq_n = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick(1'b1, 1'b0, 8'hEA);
            st($sformatf("nmi_seq%0d", t), t, 8'h00, 2, 8'hFA);
        end
        tick(1'b1, 1'b1, 8'hEA);
        st("nmi_end_masked", 0, 8'hEA, 0, 8'hFE);

        // NMI edge on the end edge: not serviced now, and IRQ still masked.
        nmi_n = 1'b1;
        tick(1'b1, 1'b0, 8'hEA);
        st("ea_t1", 1, 8'hEA, 0, 8'hFE);
        nmi_n = 1'b0;
        tick(1'b1, 1'b1, 8'hE8);
        st("coincident_nmi", 0, 8'hE8, 0, 8'hFE);

        // Unmask IRQ with NMI pending: NMI first, then IRQ.
        i_flag = 1'b0;
        tick(1'b1, 1'b0, 8'hEA);
        tick(1'b1, 1'b1, 8'hEA);
        st("prio_nmi", 0, 8'h00, 2, 8'hFA);
        tick(1'b1, 1'b0, 8'hEA);
        tick(1'b1, 1'b1, 8'hEA);
        st("prio_irq", 0, 8'h00, 1, 8'hFE);
        tick(1'b1, 1'b0, 8'hEA);
        st("irq_seq1", 1, 8'h00, 1, 8'hFE);
        irq_n = 1'b1;
        tick(1'b1, 1'b1, 8'h58);
        st("irq_end", 0, 8'h58, 0, 8'hFE);

        // Runaway instruction: 0..7 then 0 with sticky fault.
        for (int t = 1; t <= 7; t++) begin
            tick(1'b1, 1'b0, 8'hEA);
            check($sformatf("fault_t%0d", t), 32'(pla_if.tstate), t);
        end
        check("fault_before", 32'(t_fault), 0);
        tick(1'b1, 1'b0, 8'h02);
        st("fault_wrap", 0, 8'h02, 0, 8'hFE);
        check("fault_set", 32'(t_fault), 1);
        tick(1'b1, 1'b1, 8'h03);
        tick(1'b1, 1'b0, 8'hEA);
        check("fault_sticky", 32'(t_fault), 1);

        // Reset mid-instruction aborts asynchronously.
        #2 rst_n = 1'b0;
        #1;
        st("abort", 0, 8'h00, 3, 8'hFC);
        check("abort.ctrl_out", 32'(ctrl_out), 0);
        check("abort.t_fault", 32'(t_fault), 0);
        sb_q.delete();
        exp_ctrl = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1'b1, 1'b0, 8'hEA);
        st("post_abort", 1, 8'h00, 3, 8'hFC);

`ifdef SO_EN
        check("so.idle", 32'(set_v), 0);
        so_n = 1'b0;
        tick(1'b1, 1'b0, 8'hEA);
        check("so.pulse", 32'(set_v), 1);
        tick(1'b1, 1'b0, 8'hEA);
        check("so.low2", 32'(set_v), 0);
        tick(1'b1, 1'b0, 8'hEA);
        check("so.low3", 32'(set_v), 0);
        so_n = 1'b1;
        tick(1'b1, 1'b0, 8'hEA);
        check("so.rise", 32'(set_v), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
